// File: rtl/sa_job_scheduler.sv
// sa_job_scheduler: round-robin front end that time-shares one systolic matmul array between NREQ requesters.
// Define SA_JOB_SCHEDULER_PERF_EN to add the job / busy-cycle / timeout performance counters.
module sa_job_scheduler #(
    parameter int N       = 8,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 3*N+8,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_arst,
    input  logic [NREQ-1:0]               i_reqValid,
    output logic [NREQ-1:0]               o_reqReady,
    input  logic signed [NREQ*N*N*8-1:0]  i_reqA,
    input  logic signed [NREQ*N*N*8-1:0]  i_reqB,
    output logic signed [N*N*8-1:0]       o_saA,
    output logic signed [N*N*8-1:0]       o_saB,
    output logic                          o_saValidInput,
    input  logic signed [N*N*32-1:0]      i_saC,
    input  logic                          i_saValidResult,
    output logic                          o_rspValid,
    input  logic                          i_rspReady,
    output logic [IDW-1:0]                o_rspId,
    output logic signed [N*N*32-1:0]      o_rspC,
    output logic                          o_rspError
`ifdef SA_JOB_SCHEDULER_PERF_EN
    ,
    output logic [31:0]                   o_perfJobs,
    output logic [31:0]                   o_perfBusyCycles,
    output logic [15:0]                   o_perfTimeouts
`endif
);

    localparam int MAT_W = N*N*8;
    localparam int WD_W  = $clog2(TIMEOUT+1);
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    typedef enum logic [2:0] {IDLE, LAUNCH, BUSY, RESP, GAP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IDW-1:0]          rr_ptr;
    logic [IDW-1:0]          job_id;
    logic [IDW-1:0]          grant_off;
    logic [IDW-1:0]          grant_id;
    logic [IDW-1:0]          ptr_after;
    logic [IDW:0]            win_sum;
    logic [IDW:0]            nxt_sum;
    logic [NREQ-1:0]         req_rot;
    logic                    grant_any;
    logic                    accept;
    logic                    wd_expired;
    logic [WD_W-1:0]         watchdog;
    logic signed [MAT_W-1:0] sel_a;
    logic signed [MAT_W-1:0] sel_b;

    // Rotate requests so bit 0 is the requester the round-robin pointer currently favours
    assign req_rot = NREQ'({i_reqValid, i_reqValid} >> rr_ptr);

    always_comb begin
        grant_off = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (req_rot[k]) grant_off = IDW'(k);
        end
    end

    assign grant_any  = |i_reqValid;
    assign win_sum    = {1'b0, rr_ptr} + {1'b0, grant_off};
    assign grant_id   = IDW'((win_sum >= NREQ_W) ? (win_sum - NREQ_W) : win_sum);
    assign nxt_sum    = {1'b0, grant_id} + (IDW+1)'(1);
    assign ptr_after  = IDW'((nxt_sum >= NREQ_W) ? (nxt_sum - NREQ_W) : nxt_sum);
    assign accept     = (state == IDLE) && grant_any && !i_arst;
    assign wd_expired = (watchdog == WD_W'(TIMEOUT-1));
    assign o_rspId    = job_id;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (grant_id == IDW'(r)) begin
                sel_a = i_reqA[r*MAT_W +: MAT_W];
                sel_b = i_reqB[r*MAT_W +: MAT_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) state <= IDLE;
        else        state <= state_next;
    end

    // A result strobe outranks a watchdog expiry landing in the same cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = LAUNCH;
            LAUNCH:  state_next = BUSY;
            BUSY:    if (i_saValidResult || wd_expired) state_next = RESP;
            RESP:    if (i_rspReady) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_reqReady     = '0;
        o_saValidInput = 1'b0;
        o_rspValid     = 1'b0;
        case (state)
            IDLE:    if (accept) o_reqReady = NREQ'(1) << grant_id;
            LAUNCH:  o_saValidInput = 1'b1;
            RESP:    o_rspValid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            o_saA      <= '0;
            o_saB      <= '0;
            rr_ptr     <= '0;
            job_id     <= '0;
            watchdog   <= '0;
            o_rspC     <= '0;
            o_rspError <= 1'b0;
        end else begin
            if (accept) begin
                o_saA  <= sel_a;
                o_saB  <= sel_b;
                job_id <= grant_id;
                rr_ptr <= ptr_after;
            end
            if (state == LAUNCH)    watchdog <= '0;
            else if (state == BUSY) watchdog <= watchdog + WD_W'(1);
            if (state == BUSY) begin
                if (i_saValidResult) begin
                    o_rspC     <= i_saC;
                    o_rspError <= 1'b0;
                end else if (wd_expired) begin
                    o_rspC     <= '0;
                    o_rspError <= 1'b1;
                end
            end
        end
    end

`ifdef SA_JOB_SCHEDULER_PERF_EN
    // Saturating counters; only reset clears them
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            o_perfJobs       <= '0;
            o_perfBusyCycles <= '0;
            o_perfTimeouts   <= '0;
        end else begin
            if (state == RESP && i_rspReady && o_perfJobs != '1)
                o_perfJobs <= o_perfJobs + 32'd1;
            if ((state == LAUNCH || state == BUSY) && o_perfBusyCycles != '1)
                o_perfBusyCycles <= o_perfBusyCycles + 32'd1;
            if (state == RESP && i_rspReady && o_rspError && o_perfTimeouts != '1)
                o_perfTimeouts <= o_perfTimeouts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_job_scheduler.sv
// Directed testbench for sa_job_scheduler (N=4, NREQ=2) with a behavioural array model answering 3N+1 cycles after launch.
module tb_sa_job_scheduler;

    localparam int N       = 4;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 3*N+8;
    localparam int MAT_W   = N*N*8;
    localparam int RES_W   = N*N*32;

    logic                    clk = 1'b0;
    logic                    arst = 1'b1;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*MAT_W-1:0]   req_a = '0;
    logic [NREQ*MAT_W-1:0]   req_b = '0;
    logic [MAT_W-1:0]        sa_a;
    logic [MAT_W-1:0]        sa_b;
    logic                    sa_valid_in;
    logic [RES_W-1:0]        sa_c;
    logic                    sa_valid_res;
    logic                    model_valid = 1'b0;
    logic                    stray_valid = 1'b0;
    logic [RES_W-1:0]        model_c = '0;
    logic [RES_W-1:0]        pending_c = '0;
    logic [RES_W-1:0]        stray_c = '0;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b1;
    logic                    rsp_id;
    logic [RES_W-1:0]        rsp_c;
    logic                    rsp_err;
`ifdef SA_JOB_SCHEDULER_PERF_EN
    logic [31:0]             perf_jobs;
    logic [31:0]             perf_busy;
    logic [15:0]             perf_to;
`endif

    int  errors = 0;
    int  checks = 0;
    int  model_cnt = 0;
    bit  model_en = 1'b1;
    logic arst_q = 1'b1;

    assign sa_valid_res = model_valid | stray_valid;
    assign sa_c         = stray_valid ? stray_c : model_c;

    sa_job_scheduler #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk),
        .i_arst(arst),
        .i_reqValid(req_valid),
        .o_reqReady(req_ready),
        .i_reqA(req_a),
        .i_reqB(req_b),
        .o_saA(sa_a),
        .o_saB(sa_b),
        .o_saValidInput(sa_valid_in),
        .i_saC(sa_c),
        .i_saValidResult(sa_valid_res),
        .o_rspValid(rsp_valid),
        .i_rspReady(rsp_ready),
        .o_rspId(rsp_id),
        .o_rspC(rsp_c),
        .o_rspError(rsp_err)
`ifdef SA_JOB_SCHEDULER_PERF_EN
        ,
        .o_perfJobs(perf_jobs),
        .o_perfBusyCycles(perf_busy),
        .o_perfTimeouts(perf_to)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [RES_W-1:0] matmul(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        logic [RES_W-1:0] c;
        int acc;
        c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++)
                    acc += int'($signed(a[(i*N+k)*8 +: 8])) * int'($signed(b[(k*N+j)*8 +: 8]));
                c[(i*N+j)*32 +: 32] = acc;
            end
        end
        return c;
    endfunction

    // Behavioural array: shares the scheduler reset, answers in cycle LAUNCH+3N+1 unless disabled
    always @(posedge clk) arst_q <= arst;

    always @(negedge clk) begin
        model_valid = 1'b0;
        if (arst_q) begin
            model_cnt = 0;
        end else begin
            if (model_cnt > 0) begin
                model_cnt--;
                if (model_cnt == 0 && model_en) begin
                    model_valid = 1'b1;
                    model_c     = pending_c;
                end
            end
            if (sa_valid_in) begin
                model_cnt = 3*N+1;
                pending_c = matmul(sa_a, sa_b);
            end
        end
    end

    function automatic logic [MAT_W-1:0] mat_fill(input int v);
        logic [MAT_W-1:0] m;
        for (int e = 0; e < N*N; e++) m[e*8 +: 8] = v[7:0];
        return m;
    endfunction

    function automatic logic [MAT_W-1:0] mat_identity();
        logic [MAT_W-1:0] m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m[(i*N+j)*8 +: 8] = (i == j) ? 8'd1 : 8'd0;
        return m;
    endfunction

    function automatic logic [MAT_W-1:0] mat_index();
        logic [MAT_W-1:0] m;
        for (int e = 0; e < N*N; e++) m[e*8 +: 8] = 8'(e);
        return m;
    endfunction

    function automatic logic [RES_W-1:0] res_fill(input int v);
        logic [RES_W-1:0] c;
        for (int e = 0; e < N*N; e++) c[e*32 +: 32] = v;
        return c;
    endfunction

    function automatic logic [RES_W-1:0] res_index();
        logic [RES_W-1:0] c;
        for (int e = 0; e < N*N; e++) c[e*32 +: 32] = 32'(e);
        return c;
    endfunction

    // All-ones A times B[k][j]=4k+j gives column sums 4*(0+1+2+3)+4j = 24+4j
    function automatic logic [RES_W-1:0] res_ones_index();
        logic [RES_W-1:0] c;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) c[(i*N+j)*32 +: 32] = 32'(24 + 4*j);
        return c;
    endfunction

    task automatic set_req(input int r, input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        req_a[r*MAT_W +: MAT_W] = a;
        req_b[r*MAT_W +: MAT_W] = b;
    endtask

    // Called at the LAUNCH negedge; returns at the first negedge with rsp_valid high, lat=-1 if it never came
    task automatic wait_rsp(input int budget, output int lat, output int ready_seen, output int launches);
        lat = 0;
        ready_seen = 0;
        launches = 0;
        while (rsp_valid !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
            if (req_ready !== '0) ready_seen++;
            if (sa_valid_in === 1'b1) launches++;
        end
        if (rsp_valid !== 1'b1) lat = -1;
    endtask

    task automatic run_one(input logic [NREQ-1:0] mask);
        int lat, rs, ln;
        req_valid = mask;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(60, lat, rs, ln);
        checks++;
        if (lat < 0) begin errors++; $display("[TB] FAIL run_one_rsp: got no response, expected one within 60 cycles"); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        arst = 1'b1;
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({req_ready, sa_valid_in, rsp_valid, rsp_id, rsp_err} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 000000", {req_ready, sa_valid_in, rsp_valid, rsp_id, rsp_err});
        end
        checks++;
        if ({sa_a, sa_b} !== '0) begin errors++; $display("[TB] FAIL reset_sa_ab: got %h, expected 0", {sa_a, sa_b}); end
        checks++;
        if (rsp_c !== '0) begin errors++; $display("[TB] FAIL reset_rsp_c: got %h, expected 0", rsp_c); end
        req_valid = '0;
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_job();
        int lat, rs, ln;
        set_req(0, mat_identity(), mat_index());
        set_req(1, mat_fill(-128), mat_fill(127));
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_ready: got %b, expected 01", req_ready); end
        @(negedge clk);
        checks++;
        if (sa_valid_in !== 1'b1) begin errors++; $display("[TB] FAIL single_launch: got %b, expected 1", sa_valid_in); end
        checks++;
        if (sa_a !== mat_identity() || sa_b !== mat_index()) begin
            errors++; $display("[TB] FAIL single_sa_ab: got A=%h B=%h, expected identity/index", sa_a, sa_b);
        end
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL single_ready_launch: got %b, expected 00", req_ready); end
        req_valid = '0;
        wait_rsp(40, lat, rs, ln);
        checks++;
        if (lat != 3*N+2) begin errors++; $display("[TB] FAIL single_latency: got %0d, expected %0d", lat, 3*N+2); end
        checks++;
        if (ln != 0) begin errors++; $display("[TB] FAIL single_extra_launch: got %0d, expected 0", ln); end
        checks++;
        if (rsp_c !== res_index() || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL single_rsp: got id=%b err=%b C=%h, expected id=0 err=0 C=B", rsp_id, rsp_err, rsp_c);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp_drop: got %b, expected 0", rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int lat, rs, ln;
        logic [RES_W-1:0] exp_c;
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++;
            if (req_ready !== ((j % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("[TB] FAIL contention_grant%0d: got %b, expected owner %0d", j, req_ready, j % 2);
            end
            @(negedge clk);
            wait_rsp(40, lat, rs, ln);
            checks++;
            if (rs != 0) begin errors++; $display("[TB] FAIL contention_busy_ready%0d: got %0d cycles, expected 0", j, rs); end
            exp_c = (j % 2 == 0) ? res_index() : res_fill(-65024);
            checks++;
            if (lat < 0 || rsp_id !== 1'(j % 2) || rsp_c !== exp_c || rsp_err !== 1'b0) begin
                errors++; $display("[TB] FAIL contention_rsp%0d: got id=%b err=%b C=%h, expected id=%0d C=%h", j, rsp_id, rsp_err, rsp_c, j % 2, exp_c);
            end
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL contention_gap_ready%0d: got %b, expected 00", j, req_ready); end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int lat, rs, ln, stable, gap;
        set_req(0, mat_fill(1), mat_index());
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(40, lat, rs, ln);
        stable = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (rsp_valid === 1'b1 && rsp_c === res_ones_index() && rsp_id === 1'b0 && rsp_err === 1'b0) stable++;
            if (c == 5) begin
                rsp_ready = 1'b1;
                req_valid = 2'b10;
            end
        end
        checks++;
        if (stable != 6) begin errors++; $display("[TB] FAIL bp_stable: got %0d cycles, expected 6", stable); end
        gap = 0;
        while (gap < 10) begin
            @(negedge clk);
            gap++;
            if (sa_valid_in === 1'b1) break;
        end
        checks++;
        if (gap != 3) begin errors++; $display("[TB] FAIL bp_next_launch: got %0d cycles after handshake, expected 3", gap); end
        req_valid = '0;
        wait_rsp(40, lat, rs, ln);
        checks++;
        if (lat < 0 || rsp_id !== 1'b1 || rsp_c !== res_fill(-65024)) begin
            errors++; $display("[TB] FAIL bp_followup: got lat=%0d id=%b C=%h, expected id=1", lat, rsp_id, rsp_c);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int lat, rs, ln;
        set_req(0, mat_identity(), mat_index());
        model_en = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL to_grant: got %b, expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b10;
        wait_rsp(60, lat, rs, ln);
        // Expiry is decided in the TIMEOUT-th cycle after launch, so the response shows one cycle later
        checks++;
        if (lat != TIMEOUT+1) begin errors++; $display("[TB] FAIL to_latency: got %0d, expected %0d", lat, TIMEOUT+1); end
        checks++;
        if (rsp_err !== 1'b1 || rsp_c !== '0 || rsp_id !== 1'b0) begin
            errors++; $display("[TB] FAIL to_rsp: got err=%b id=%b C=%h, expected err=1 id=0 C=0", rsp_err, rsp_id, rsp_c);
        end
        checks++;
        if (rs != 0) begin errors++; $display("[TB] FAIL to_busy_ready: got %0d, expected 0", rs); end
        model_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL to_queued_grant: got %b, expected 10", req_ready); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(40, lat, rs, ln);
        checks++;
        if (lat != 3*N+2 || rsp_err !== 1'b0 || rsp_id !== 1'b1 || rsp_c !== res_fill(-65024)) begin
            errors++; $display("[TB] FAIL to_queued_rsp: got lat=%0d err=%b id=%b C=%h, expected lat=%0d err=0 id=1", lat, rsp_err, rsp_id, rsp_c, 3*N+2);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int lat, rs, ln, seen;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        #1;
        checks++;
        if ({req_ready, sa_valid_in, rsp_valid, rsp_id, rsp_err} !== 6'b0 || {sa_a, sa_b} !== '0 || rsp_c !== '0) begin
            errors++; $display("[TB] FAIL midrst_outputs: got ctrl=%b A=%h C=%h, expected all 0", {req_ready, sa_valid_in, rsp_valid, rsp_id, rsp_err}, sa_a, rsp_c);
        end
        @(negedge clk);
        stray_c = res_fill(7);
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("[TB] FAIL midrst_no_rsp: got %0d valid cycles, expected 0", seen); end
        checks++;
        if (rsp_c !== '0) begin errors++; $display("[TB] FAIL midrst_stray: got %h, expected 0", rsp_c); end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL midrst_rr_ptr: got %b, expected 01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(40, lat, rs, ln);
        checks++;
        if (lat != 3*N+2 || rsp_id !== 1'b0 || rsp_c !== res_index()) begin
            errors++; $display("[TB] FAIL midrst_next_job: got lat=%0d id=%b C=%h, expected lat=%0d id=0", lat, rsp_id, rsp_c, 3*N+2);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

`ifdef SA_JOB_SCHEDULER_PERF_EN
    task automatic test_perf();
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        repeat (3) run_one(2'b01);
        model_en = 1'b0;
        run_one(2'b01);
        model_en = 1'b1;
        checks++;
        if (perf_jobs !== 32'd4) begin errors++; $display("[TB] FAIL perf_jobs: got %0d, expected 4", perf_jobs); end
        checks++;
        if (perf_to !== 16'd1) begin errors++; $display("[TB] FAIL perf_timeouts: got %0d, expected 1", perf_to); end
        checks++;
        if (perf_busy !== 32'(3*14 + TIMEOUT + 1)) begin
            errors++; $display("[TB] FAIL perf_busy: got %0d, expected %0d", perf_busy, 3*14 + TIMEOUT + 1);
        end
    endtask
`endif

    initial begin
        $display("[TB] sa_job_scheduler bench start");
        test_reset();
        test_single_job();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_mid_busy();
`ifdef SA_JOB_SCHEDULER_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
